// File: rtl/rx_front_end.sv
// rx_front_end: synchronizer, glitch filter, start-edge pulse, mid-bit baud strobe and line-break flag.
// Latency: raw edge reaches rx_pin_out FILTER_LEN+2 edges later; h2l_sig follows one edge after that.
// Backpressure: none; count_sig from the receiver only gates the edge pulse and the baud generator.
module rx_front_end #(
    parameter int BPS_DIV    = 5208,
    parameter int FILTER_LEN = 3,
    parameter int BREAK_BITS = 11
) (
    input  logic clk,
    input  logic rstn,
    input  logic rx_pin_raw,
    input  logic count_sig,
    output logic rx_pin_out,
    output logic h2l_sig,
    output logic bps_clk,
    output logic break_sig
);

    // Counter widths: filter counter keeps one spare bit so FILTER_LEN = 1 still gets a 1-bit counter.
    localparam int FW      = $clog2(FILTER_LEN) + 1;
    localparam int BW      = (BPS_DIV > 1) ? $clog2(BPS_DIV) : 1;
    localparam int KLEN    = BREAK_BITS * BPS_DIV;
    localparam int KW      = (KLEN > 1) ? $clog2(KLEN) : 1;

    localparam logic [FW-1:0] FILT_LAST = FW'(FILTER_LEN - 1);
    localparam logic [FW-1:0] FILT_ONE  = FW'(1);
    localparam logic [BW-1:0] BPS_LAST  = BW'(BPS_DIV - 1);
    localparam logic [BW-1:0] BPS_MID   = BW'(BPS_DIV / 2);
    localparam logic [BW-1:0] BPS_ONE   = BW'(1);
    localparam logic [KW-1:0] BRK_LAST  = KW'(KLEN - 1);
    localparam logic [KW-1:0] BRK_ONE   = KW'(1);

    logic          sync_q1;
    logic          sync;
    logic          filt;
    logic          filt_d;
    logic [FW-1:0] fcnt;
    logic [BW-1:0] bcnt;
    logic [KW-1:0] kcnt;

    assign rx_pin_out = filt;

    // Two-flop synchronizer; resets to the idle-high line level.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            sync_q1 <= 1'b1;
            sync    <= 1'b1;
        end else begin
            sync_q1 <= rx_pin_raw;
            sync    <= sync_q1;
        end
    end

    // Glitch filter: the line only changes after FILTER_LEN consecutive differing samples.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            filt <= 1'b1;
            fcnt <= '0;
        end else if (sync == filt) begin
            fcnt <= '0;
        end else if (fcnt == FILT_LAST) begin
            filt <= sync;
            fcnt <= '0;
        end else begin
            fcnt <= fcnt + FILT_ONE;
        end
    end

    // Start-edge detect: falls seen while a frame is in progress (data bits) never pulse.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            filt_d  <= 1'b1;
            h2l_sig <= 1'b0;
        end else begin
            filt_d  <= filt;
            h2l_sig <= filt_d & ~filt & ~count_sig;
        end
    end

    // Baud generator: phase restarts whenever count_sig drops, strobe lands at the bit centre.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            bcnt    <= '0;
            bps_clk <= 1'b0;
        end else if (!count_sig) begin
            bcnt    <= '0;
            bps_clk <= 1'b0;
        end else begin
            bcnt    <= (bcnt == BPS_LAST) ? '0 : bcnt + BPS_ONE;
            bps_clk <= (bcnt == BPS_MID);
        end
    end

    // Break detector: saturating low-time counter, flag held until the filtered line returns high.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            kcnt      <= '0;
            break_sig <= 1'b0;
        end else if (filt) begin
            kcnt      <= '0;
            break_sig <= 1'b0;
        end else begin
            if (kcnt != BRK_LAST) begin
                kcnt <= kcnt + BRK_ONE;
            end
            if (kcnt == BRK_LAST) begin
                break_sig <= 1'b1;
            end
        end
    end

endmodule
